mult_div_unit: RTL and testbench

- E-stage multiply/divide unit of the P6 pipeline; owns the HI/LO registers.
- Produces the `busy` signal that the hazard unit combines with the decoded `start` to stall HI/LO-class instructions in D.
- Executes MULT/MULTU/DIV/DIVU as multi-cycle operations using the forwarded rs/rt values from E.
- Executes MTHI/MTLO in one cycle and supplies HI/LO readback for MFHI/MFLO.

---
 rtl/mult_div_unit.sv | 108 ++++++++++
 tb/tb_mult_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit that owns HI/LO.
// Multi-cycle MULT/MULTU/DIV/DIVU with a busy window, single-cycle MTHI/MTLO
// and combinational MFHI/MFLO readback.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd
);
    localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = ($clog2(MAX_N + 1) > 4) ? $clog2(MAX_N + 1) : 4;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag, b_mag, den_s, den_u;
    logic [31:0] uq, ur, sq, sr, q_u, r_u;

    // busy comes from registered state only, so start never feeds it directly
    assign busy = (cnt != '0);
    assign rd   = hilo_sel ? hi : lo;

    // Arithmetic on the latched operands; signed divide goes through magnitudes
    // so the 0x80000000 / -1 case falls out naturally as 0x80000000 rem 0.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        a_mag  = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag  = b_q[31] ? (32'd0 - b_q) : b_q;
        // divisor forced nonzero; the zero-divisor case never writes back anyway
        den_s  = (b_q == 32'd0) ? 32'd1 : b_mag;
        den_u  = (b_q == 32'd0) ? 32'd1 : b_q;
        uq     = a_mag / den_s;
        ur     = a_mag % den_s;
        sq     = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
        sr     = a_q[31] ? (32'd0 - ur) : ur;
        q_u    = a_q / den_u;
        r_u    = a_q % den_u;
    end

    // Operation sequencing: accept when idle, count down, write HI/LO at cnt==1
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            op_q <= 2'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (cnt != '0) begin
            // starts during busy are ignored entirely
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
                case (op_q)
                    2'd0: {hi, lo} <= prod_s;
                    2'd1: {hi, lo} <= prod_u;
                    2'd2: if (b_q != 32'd0) begin
                        hi <= sr;
                        lo <= sq;
                    end
                    default: if (b_q != 32'd0) begin
                        hi <= r_u;
                        lo <= q_u;
                    end
                endcase
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    op_q <= op[1:0];
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= CNT_W'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    op_q <= op[1:0];
                    a_q  <= a;
                    b_q  <= b;
                    cnt  <= CNT_W'(DIV_CYCLES);
                end
                OP_MTHI: hi <= a;
                OP_MTLO: lo <= a;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench. Stimulus pushes expected HI/LO and busy
// length per multi-cycle op; a negedge monitor checks hold values during busy
// and the result when busy falls.
module tb_mult_div_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk, reset, start, hilo_sel, busy;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo, rd;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hilo_sel(hilo_sel), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi, lo, pre_hi, pre_lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          pass  = 0;
    logic [31:0] hi_m = 0, lo_m = 0;
    int          bcnt = 0;
    bit          pbusy = 0;
    exp_t        e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference model: plain integer arithmetic on whole operands
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] eh, output logic [31:0] el);
        longint          ps;
        longint unsigned pu;
        int              sx, sy;
        eh = hi_m;
        el = lo_m;
        sx = x;
        sy = y;
        case (o)
            3'd0: begin ps = longint'(sx) * longint'(sy); {eh, el} = ps; end
            3'd1: begin pu = longint'({32'd0, x}) * longint'({32'd0, y}); {eh, el} = pu; end
            3'd2: if (y != 0) begin
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000; eh = 0;
                end else begin
                    el = sx / sy; eh = sx % sy;
                end
            end
            3'd3: if (y != 0) begin el = x / y; eh = x % y; end
            default: ;
        endcase
    endtask

    // Issue one op from idle; for multi-cycle ops, optionally scribble on the
    // inputs (including stray starts) every cycle until busy drops.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit junk);
        exp_t en;
        int   n;
        if (o <= 3) begin
            en.pre_hi = hi_m;
            en.pre_lo = lo_m;
            model(o, x, y, en.hi, en.lo);
            en.len = (o <= 1) ? MC : DC;
            sb.push_back(en);
            hi_m = en.hi;
            lo_m = en.lo;
        end
        start = 1; op = o; a = x; b = y; hilo_sel = 1'($urandom);
        @(posedge clk); #1;
        start = 0; a = $urandom; b = $urandom;
        case (o)
            3'd4: begin hi_m = x; chk("mthi", hi, hi_m); chk("mthi_lo_keep", lo, lo_m); end
            3'd5: begin lo_m = x; chk("mtlo", lo, lo_m); chk("mtlo_hi_keep", hi, hi_m); end
            3'd6, 3'd7: begin chk("nop_hi", hi, hi_m); chk("nop_lo", lo, lo_m); chk("nop_busy", 32'(busy), 0); end
            default: begin
                chk("busy_rise", 32'(busy), 1);
                n = 0;
                while (busy && n < 40) begin
                    if (junk) begin
                        start = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
                        hilo_sel = 1'($urandom);
                    end
                    @(posedge clk); #1;
                    n++;
                end
                start = 0;
                if (busy) chk("busy_timeout", 32'(busy), 0);
            end
        endcase
    endtask

    // Monitor: hold values during busy, result and busy length at the fall
    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            bcnt  = 0;
            pbusy = 0;
        end else begin
            if (busy) begin
                bcnt++;
                if (sb.size() > 0) begin
                    chk("hold_hi", hi, sb[0].pre_hi);
                    chk("hold_lo", lo, sb[0].pre_lo);
                    chk("hold_rd", rd, hilo_sel ? sb[0].pre_hi : sb[0].pre_lo);
                end
            end else if (pbusy) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    chk("res_hi", hi, e.hi);
                    chk("res_lo", lo, e.lo);
                    chk("res_rd", rd, hilo_sel ? e.hi : e.lo);
                    chk("busy_len", 32'(bcnt), 32'(e.len));
                end
                bcnt = 0;
            end
            pbusy = busy;
        end
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;
        clk = 0; reset = 1; start = 0; op = 0; a = 0; b = 0; hilo_sel = 0;
        #2 reset = 0;
        #8;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", 32'(busy), 0);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;

        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        hilo_sel = 1; #1 chk("rd_hi", rd, 32'hFFFF_FFFE);
        hilo_sel = 0; #1 chk("rd_lo", rd, 32'h0000_0001);
        @(posedge clk); #1;
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd2, 0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        issue(3'd4, 32'h11, 32'd0, 0);
        issue(3'd5, 32'h22, 32'd0, 0);
        issue(3'd2, 32'h1234, 32'd0, 0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        issue(3'd3, 32'h1234, 32'd0, 0);
        issue(3'd6, 32'hDEAD, 32'hBEEF, 0);

        // Operands churn and an MTLO pulses mid-busy; result must use latched values
        sb.push_back('{hi: 32'd0, lo: 32'd42, pre_hi: hi_m, pre_lo: lo_m, len: MC});
        hi_m = 0; lo_m = 42;
        start = 1; op = 3'd0; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        start = 0;
        for (int i = 0; i < MC; i++) begin
            a = $urandom; b = $urandom;
            if (i == 1) begin start = 1; op = 3'd5; end
            else start = 0;
            @(posedge clk); #1;
        end
        start = 0;
        chk("churn_busy_done", 32'(busy), 0);
        chk("churn_lo", lo, 32'd42);

        // Random ops with junk traffic during busy
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom);
            rx = $urandom;
            ry = ($urandom_range(3) == 0) ? 32'd0 :
                 ($urandom_range(1) == 0) ? 32'($urandom_range(20)) : $urandom;
            issue(ro, rx, ry, 1);
        end

        // Reset mid-DIV: abort with no late write-back
        start = 1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        @(posedge clk); #1 reset = 1;
        hi_m = 0; lo_m = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (busy) chk("post_rst_busy", 32'(busy), 0);
        end
        chk("post_rst_hi", hi, 0);
        chk("post_rst_lo", lo, 0);
        chk("post_rst_busy_end", 32'(busy), 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
